// File: rtl/led_phase_sequencer.sv
// rtl/led_phase_sequencer.sv - IR/RED/dark LED phase sequencer with averaged, ambient-corrected ADC results
module led_phase_sequencer #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned AVG_LOG2   = 2,
    parameter bit          DARK_EN    = 1'b1
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] ADC,
    output logic       LED_IR,
    output logic       LED_RED,
    output logic       adc_sample,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] Ambient_Value,
    output logic       frame_valid,
    input  logic       frame_ack,
    output logic       overrun,
    output logic       busy
);
    localparam int unsigned ACC_W = 8 + AVG_LOG2;
    localparam int unsigned N     = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        IDLE,
        IR_SETTLE,
        IR_SAMPLE,
        RED_SETTLE,
        RED_SAMPLE,
        DARK_SETTLE,
        DARK_SAMPLE,
        PUBLISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cnt;
    logic [ACC_W-1:0] acc_ir;
    logic [ACC_W-1:0] acc_red;
    logic [ACC_W-1:0] acc_dark;
    logic [7:0]       avg_ir;
    logic [7:0]       avg_red;
    logic [7:0]       avg_dark;
    logic [8:0]       diff_ir;
    logic [8:0]       diff_red;
    logic [7:0]       corr_ir;
    logic [7:0]       corr_red;

    // The accumulator never exceeds 255*N, so its top 8 bits are exactly acc >> AVG_LOG2.
    assign avg_ir   = acc_ir[AVG_LOG2 +: 8];
    assign avg_red  = acc_red[AVG_LOG2 +: 8];
    assign avg_dark = DARK_EN ? acc_dark[AVG_LOG2 +: 8] : 8'd0;

    assign diff_ir  = {1'b0, avg_ir} - {1'b0, avg_dark};
    assign diff_red = {1'b0, avg_red} - {1'b0, avg_dark};
    assign corr_ir  = diff_ir[8] ? 8'd0 : diff_ir[7:0];
    assign corr_red = diff_red[8] ? 8'd0 : diff_red[7:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (enable) state_nxt = IR_SETTLE;
            IR_SETTLE:   if (cnt == 8'd0) state_nxt = IR_SAMPLE;
            IR_SAMPLE:   if (cnt == 8'd0) state_nxt = RED_SETTLE;
            RED_SETTLE:  if (cnt == 8'd0) state_nxt = RED_SAMPLE;
            RED_SAMPLE:  if (cnt == 8'd0) state_nxt = DARK_EN ? DARK_SETTLE : PUBLISH;
            DARK_SETTLE: if (cnt == 8'd0) state_nxt = DARK_SAMPLE;
            DARK_SAMPLE: if (cnt == 8'd0) state_nxt = PUBLISH;
            PUBLISH:     state_nxt = enable ? IR_SETTLE : IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the LEDs change on the same edge as the state.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            acc_ir        <= '0;
            acc_red       <= '0;
            acc_dark      <= '0;
            LED_IR        <= 1'b0;
            LED_RED       <= 1'b0;
            adc_sample    <= 1'b0;
            busy          <= 1'b0;
            IR_ADC_Value  <= 8'd0;
            RED_ADC_Value <= 8'd0;
            Ambient_Value <= 8'd0;
            frame_valid   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state      <= state_nxt;
            LED_IR     <= (state_nxt == IR_SETTLE) || (state_nxt == IR_SAMPLE);
            LED_RED    <= (state_nxt == RED_SETTLE) || (state_nxt == RED_SAMPLE);
            adc_sample <= (state_nxt == IR_SAMPLE) || (state_nxt == RED_SAMPLE) ||
                          (state_nxt == DARK_SAMPLE);
            busy       <= (state_nxt != IDLE);

            if (state_nxt != state) begin
                if ((state_nxt == IR_SETTLE) || (state_nxt == RED_SETTLE) ||
                    (state_nxt == DARK_SETTLE))
                    cnt <= 8'(SETTLE_CYC - 1);
                else if ((state_nxt == IR_SAMPLE) || (state_nxt == RED_SAMPLE) ||
                         (state_nxt == DARK_SAMPLE))
                    cnt <= 8'(N - 1);
                else
                    cnt <= 8'd0;
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end

            if (state == IR_SAMPLE)
                acc_ir <= acc_ir + ACC_W'(ADC);
            else if ((state_nxt == IR_SETTLE) && (state != IR_SETTLE))
                acc_ir <= '0;

            if (state == RED_SAMPLE)
                acc_red <= acc_red + ACC_W'(ADC);
            else if ((state_nxt == RED_SETTLE) && (state != RED_SETTLE))
                acc_red <= '0;

            if (state == DARK_SAMPLE)
                acc_dark <= acc_dark + ACC_W'(ADC);
            else if ((state_nxt == DARK_SETTLE) && (state != DARK_SETTLE))
                acc_dark <= '0;

            // A publish always wins over an ack in the same cycle; overrun only when it lands on an unacked frame.
            if (state == PUBLISH) begin
                IR_ADC_Value  <= corr_ir;
                RED_ADC_Value <= corr_red;
                Ambient_Value <= avg_dark;
                frame_valid   <= 1'b1;
                overrun       <= frame_valid & ~frame_ack;
            end else if (frame_valid && frame_ack) begin
                frame_valid <= 1'b0;
                overrun     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_led_phase_sequencer.sv
// tb/tb_led_phase_sequencer.sv - scoreboard bench for led_phase_sequencer, dark phase on and off builds
module tb_led_phase_sequencer;
    typedef struct {
        logic [7:0] ir;
        logic [7:0] red;
        logic [7:0] amb;
        logic       ovr;
    } exp_t;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       en0, en1, frame_ack;
    logic       ack1 = 1'b0;
    logic [7:0] adc0, adc1;
    logic       led_ir0, led_red0, as0, fv0, ovr0, busy0;
    logic       led_ir1, led_red1, as1, fv1, ovr1, busy1;
    logic [7:0] ir0, red0, amb0, ir1, red1, amb1;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] ir_t[4];
    logic [7:0] red_t[4];
    logic [7:0] dark_t[4];
    int         idx0, idx1;

    bit          cur_sel = 1'b0;
    logic [27:1] obs_ir, obs_red, obs_as, obs_busy, obs_fv;
    logic        pend0 = 0, pend1 = 0, pa0 = 0, pd0 = 0, pa1 = 0, pr1 = 0;

    always #5 CLK = ~CLK;

    led_phase_sequencer #(.SETTLE_CYC(4), .AVG_LOG2(2), .DARK_EN(1'b1)) u_dut0 (
        .CLK(CLK), .rst_n(rst_n), .enable(en0), .ADC(adc0),
        .LED_IR(led_ir0), .LED_RED(led_red0), .adc_sample(as0),
        .IR_ADC_Value(ir0), .RED_ADC_Value(red0), .Ambient_Value(amb0),
        .frame_valid(fv0), .frame_ack(frame_ack), .overrun(ovr0), .busy(busy0)
    );

    led_phase_sequencer #(.SETTLE_CYC(4), .AVG_LOG2(2), .DARK_EN(1'b0)) u_dut1 (
        .CLK(CLK), .rst_n(rst_n), .enable(en1), .ADC(adc1),
        .LED_IR(led_ir1), .LED_RED(led_red1), .adc_sample(as1),
        .IR_ADC_Value(ir1), .RED_ADC_Value(red1), .Ambient_Value(amb1),
        .frame_valid(fv1), .frame_ack(ack1), .overrun(ovr1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] pick(input logic ir, input logic red, input int i);
        if (ir) return ir_t[i];
        if (red) return red_t[i];
        return dark_t[i];
    endfunction

    function automatic logic [27:1] rng(input int lo, input int hi);
        logic [27:1] v;
        v = '0;
        for (int c = 1; c <= 27; c++)
            if (c >= lo && c <= hi) v[c] = 1'b1;
        return v;
    endfunction

    task automatic set_all(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
        for (int i = 0; i < 4; i++) begin
            ir_t[i] = a; red_t[i] = b; dark_t[i] = d;
        end
    endtask

    task automatic push0(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d, input logic o);
        exp_t e;
        e.ir = a; e.red = b; e.amb = d; e.ovr = o;
        q0.push_back(e);
    endtask

    // Start one frame with enable, drop enable at drop_cyc, optionally ack during the PUBLISH cycle (25).
    task automatic run_frame(input bit sel, input int drop_cyc, input bit ack_pub);
        cur_sel = sel;
        @(negedge CLK);
        if (sel) en1 = 1'b1; else en0 = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= 27; c++) begin
            @(negedge CLK);
            obs_ir[c]   = sel ? led_ir1 : led_ir0;
            obs_red[c]  = sel ? led_red1 : led_red0;
            obs_as[c]   = sel ? as1 : as0;
            obs_busy[c] = sel ? busy1 : busy0;
            obs_fv[c]   = sel ? fv1 : fv0;
            if (c == drop_cyc) begin en0 = 1'b0; en1 = 1'b0; end
            if (ack_pub && c == 25) frame_ack = 1'b1;
            if (c == 26) frame_ack = 1'b0;
        end
    endtask

    task automatic do_ack();
        @(negedge CLK);
        frame_ack = 1'b1;
        @(negedge CLK);
        frame_ack = 1'b0;
        chk("ack clears valid/overrun", {fv0, ovr0}, 2'b00);
    endtask

    // Optical front end: ADC value follows the lit LED and the sample index within the phase.
    initial begin
        adc0 = 8'd0; adc1 = 8'd0; idx0 = 0; idx1 = 0;
        forever begin
            @(negedge CLK);
            if (as0) begin adc0 = pick(led_ir0, led_red0, idx0 & 3); idx0++; end else idx0 = 0;
            if (as1) begin adc1 = pick(led_ir1, led_red1, idx1 & 3); idx1++; end else idx1 = 0;
        end
    end

    // Monitor: a frame is due one cycle after the last sampling phase ends (the PUBLISH cycle).
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (pend0) begin
                pend0 = 1'b0;
                n_cmp++;
                if (q0.size() == 0) begin
                    n_bad++;
                    $display("FAIL dut0 frame: got unexpected frame, expected none");
                end else begin
                    n_cmp--;
                    e = q0.pop_front();
                    chk("dut0 frame {fv,ovr,ir,red,amb}", {fv0, ovr0, ir0, red0, amb0},
                        {1'b1, e.ovr, e.ir, e.red, e.amb});
                end
            end
            if (pend1) begin
                pend1 = 1'b0;
                n_cmp++;
                if (q1.size() == 0) begin
                    n_bad++;
                    $display("FAIL dut1 frame: got unexpected frame, expected none");
                end else begin
                    n_cmp--;
                    e = q1.pop_front();
                    chk("dut1 frame {fv,ovr,ir,red,amb}", {fv1, ovr1, ir1, red1, amb1},
                        {1'b1, e.ovr, e.ir, e.red, e.amb});
                end
            end
            if (pa0 && pd0 && !as0) pend0 = 1'b1;
            if (pa1 && pr1 && !as1) pend1 = 1'b1;
            pa0 = as0; pd0 = as0 && !led_ir0 && !led_red0;
            pa1 = as1; pr1 = as1 && led_red1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  idle_acc;
        logic [27:1] lowbusy;
        exp_t        e1;
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; frame_ack = 1'b0;
        set_all(8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge CLK);
        chk("reset outputs dut0", {led_ir0, led_red0, as0, ir0, red0, amb0, fv0, ovr0, busy0}, '0);
        chk("reset outputs dut1", {led_ir1, led_red1, as1, ir1, red1, amb1, fv1, ovr1, busy1}, '0);
        rst_n = 1'b1;
        idle_acc = '0;
        repeat (20) begin
            @(negedge CLK);
            idle_acc |= {busy0, led_ir0, led_red0, fv0, busy1, led_ir1, led_red1, fv1};
        end
        chk("idle with enable low", idle_acc, '0);

        // Basic frame
        set_all(8'd100, 8'd60, 8'd10);
        push0(8'd90, 8'd50, 8'd10, 1'b0);
        run_frame(1'b0, 1, 1'b0);
        chk("basic LED_IR cycles", obs_ir, rng(1, 8));
        chk("basic LED_RED cycles", obs_red, rng(9, 16));
        chk("basic adc_sample cycles", obs_as, rng(5, 8) | rng(13, 16) | rng(21, 24));
        chk("basic busy cycles", obs_busy, rng(1, 25));
        chk("basic frame_valid after 25 cycles", obs_fv, rng(26, 27));
        chk("LEDs never both on", |(obs_ir & obs_red), 1'b0);
        do_ack();

        // Truncating average
        ir_t = '{8'd1, 8'd2, 8'd2, 8'd2};
        for (int i = 0; i < 4; i++) begin red_t[i] = 8'd60; dark_t[i] = 8'd0; end
        push0(8'd1, 8'd60, 8'd0, 1'b0);
        run_frame(1'b0, 1, 1'b0);
        do_ack();

        // Saturation at 0
        set_all(8'd50, 8'd30, 8'd200);
        push0(8'd0, 8'd0, 8'd200, 1'b0);
        run_frame(1'b0, 1, 1'b0);
        do_ack();
        set_all(8'd255, 8'd255, 8'd255);
        push0(8'd0, 8'd0, 8'd255, 1'b0);
        run_frame(1'b0, 1, 1'b0);
        do_ack();

        // Overrun across two unacked frames, then ack
        set_all(8'd80, 8'd40, 8'd20);
        push0(8'd60, 8'd20, 8'd20, 1'b0);
        run_frame(1'b0, 1, 1'b0);
        set_all(8'd120, 8'd70, 8'd5);
        push0(8'd115, 8'd65, 8'd5, 1'b1);
        run_frame(1'b0, 1, 1'b0);
        do_ack();

        // Ack coinciding with PUBLISH: publish wins, no overrun
        set_all(8'd30, 8'd20, 8'd10);
        push0(8'd20, 8'd10, 8'd10, 1'b0);
        run_frame(1'b0, 1, 1'b0);
        set_all(8'd200, 8'd100, 8'd50);
        push0(8'd150, 8'd50, 8'd50, 1'b0);
        run_frame(1'b0, 1, 1'b1);
        chk("valid held after ack in PUBLISH", {fv0, ovr0}, 2'b10);
        do_ack();

        // Enable dropped during RED_SAMPLE
        set_all(8'd100, 8'd60, 8'd10);
        push0(8'd90, 8'd50, 8'd10, 1'b0);
        run_frame(1'b0, 14, 1'b0);
        chk("enable drop completes then idles",
            {obs_busy[25], obs_busy[27:26], obs_ir[27:26], obs_red[27:26]}, 7'b1000000);

        // Asynchronous reset mid IR_SAMPLE with a valid frame held
        @(negedge CLK);
        en0 = 1'b1;
        @(posedge CLK);
        repeat (5) @(posedge CLK);
        #2;
        chk("IR lit and sampling before reset", {led_ir0, as0, fv0}, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("async reset clears outputs",
            {led_ir0, led_red0, as0, ir0, red0, amb0, fv0, ovr0, busy0}, '0);
        en0 = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;

        // Dark phase disabled build
        set_all(8'd100, 8'd60, 8'd10);
        e1.ir = 8'd100; e1.red = 8'd60; e1.amb = 8'd0; e1.ovr = 1'b0;
        q1.push_back(e1);
        run_frame(1'b1, 1, 1'b0);
        chk("no-dark LED_IR cycles", obs_ir, rng(1, 8));
        chk("no-dark LED_RED cycles", obs_red, rng(9, 16));
        chk("no-dark frame_valid after 17 cycles", obs_fv, rng(18, 27));
        lowbusy = obs_busy & ~obs_ir & ~obs_red;
        chk("no-dark LEDs low while busy only in PUBLISH", lowbusy, rng(17, 17));

        repeat (3) @(negedge CLK);
        chk("all dut0 frames delivered", q0.size(), 0);
        chk("all dut1 frames delivered", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
